// File: rtl/dds_wave_gen.sv
// dds_wave_gen: phase-accumulator waveform generator.
// Stage 1 advances the phase on each qualified Ready&Enable strobe; stage 2
// turns the updated phase into one DAC code (square/saw/triangle/sine).
// Waveform changes are deferred to the phase wrap so a period is never cut.
`timescale 1ns/1ps
module dds_wave_gen #(
  parameter int PHASE_W = 16,
  parameter int DATA_W  = 8,
  parameter int LUT_AW  = 6    // must equal DATA_W-2
) (
  input  logic               Fg_CLK,
  input  logic               RESETn,
  input  logic               Ready,
  input  logic               Enable,
  input  logic [PHASE_W-1:0] TuneWord,
  input  logic [1:0]         WaveSel,
  input  logic               WaveSelStb,
  output logic [DATA_W-1:0]  DacData,
  output logic               DacValid,
  output logic               PhaseWrap
);

  typedef enum logic [1:0] {
    WAVE_SQUARE = 2'd0,
    WAVE_SAW    = 2'd1,
    WAVE_TRI    = 2'd2,
    WAVE_SINE   = 2'd3
  } wave_e;

  localparam logic [DATA_W-1:0] MIDSCALE = {1'b1, {(DATA_W-1){1'b0}}};

  // Quarter-wave table: round(127*sin((n+0.5)*pi/128)), n = 0..63 (8-bit codes).
  localparam logic [6:0] SINE_LUT [64] = '{
    7'd2,   7'd5,   7'd8,   7'd11,  7'd14,  7'd17,  7'd20,  7'd23,
    7'd26,  7'd29,  7'd32,  7'd35,  7'd38,  7'd41,  7'd44,  7'd47,
    7'd50,  7'd53,  7'd56,  7'd58,  7'd61,  7'd64,  7'd67,  7'd69,
    7'd72,  7'd74,  7'd77,  7'd79,  7'd82,  7'd84,  7'd86,  7'd89,
    7'd91,  7'd93,  7'd95,  7'd97,  7'd99,  7'd101, 7'd103, 7'd105,
    7'd106, 7'd108, 7'd110, 7'd111, 7'd113, 7'd114, 7'd115, 7'd117,
    7'd118, 7'd119, 7'd120, 7'd121, 7'd122, 7'd123, 7'd124, 7'd124,
    7'd125, 7'd125, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127, 7'd127
  };

  // Stage-1 state
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               s1_valid_q, s1_valid_d;
  logic               s1_wrap_q, s1_wrap_d;
  wave_e              act_sel_q, act_sel_d;
  wave_e              pend_sel_q, pend_sel_d;
  // Stage-2 (output) state
  logic [DATA_W-1:0]  dac_q, dac_d;
  logic               valid_q, valid_d;
  logic               wrap_q, wrap_d;

  logic [PHASE_W:0]   phase_sum;
  logic [DATA_W-1:0]  p_top;
  logic [DATA_W-1:0]  wave_code;
  logic [LUT_AW-1:0]  lut_addr;
  logic [DATA_W-2:0]  lut_val;

  // Stage 1: accumulate on qualified strobes, defer sel change to the wrap edge
  always_comb begin
    pend_sel_d = WaveSelStb ? wave_e'(WaveSel) : pend_sel_q;
    phase_sum  = {1'b0, phase_q} + {1'b0, TuneWord};
    phase_d    = phase_q;
    s1_valid_d = 1'b0;
    s1_wrap_d  = 1'b0;
    act_sel_d  = act_sel_q;
    if (!Ready) begin
      phase_d   = '0;
      act_sel_d = pend_sel_d;
    end else if (Enable) begin
      phase_d    = phase_sum[PHASE_W-1:0];
      s1_valid_d = 1'b1;
      s1_wrap_d  = phase_sum[PHASE_W];
      if (phase_sum[PHASE_W]) begin
        act_sel_d = pend_sel_d;
      end
    end
  end

  // Waveform shaping from the stage-1 phase and active selection
  always_comb begin
    p_top     = phase_q[PHASE_W-1 -: DATA_W];
    lut_addr  = p_top[DATA_W-2] ? ~p_top[LUT_AW-1:0] : p_top[LUT_AW-1:0];
    lut_val   = (DATA_W-1)'(SINE_LUT[lut_addr]);
    wave_code = MIDSCALE;
    unique case (act_sel_q)
      WAVE_SQUARE: wave_code = {DATA_W{p_top[DATA_W-1]}};
      WAVE_SAW:    wave_code = p_top;
      WAVE_TRI:    wave_code = p_top[DATA_W-1] ? ~{p_top[DATA_W-2:0], 1'b0}
                                               :  {p_top[DATA_W-2:0], 1'b0};
      WAVE_SINE:   wave_code = p_top[DATA_W-1] ? {1'b0, ~lut_val}
                                               : {1'b1,  lut_val};
      default:     wave_code = MIDSCALE;
    endcase
  end

  // Stage 2: register the code; Ready low flushes to idle midscale
  always_comb begin
    dac_d   = dac_q;
    valid_d = 1'b0;
    wrap_d  = 1'b0;
    if (!Ready) begin
      dac_d = MIDSCALE;
    end else if (s1_valid_q) begin
      dac_d   = wave_code;
      valid_d = 1'b1;
      wrap_d  = s1_wrap_q;
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge Fg_CLK or negedge RESETn) begin
    if (!RESETn) begin
      phase_q    <= '0;
      s1_valid_q <= 1'b0;
      s1_wrap_q  <= 1'b0;
      act_sel_q  <= WAVE_SQUARE;
      pend_sel_q <= WAVE_SQUARE;
      dac_q      <= MIDSCALE;
      valid_q    <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      s1_valid_q <= s1_valid_d;
      s1_wrap_q  <= s1_wrap_d;
      act_sel_q  <= act_sel_d;
      pend_sel_q <= pend_sel_d;
      dac_q      <= dac_d;
      valid_q    <= valid_d;
      wrap_q     <= wrap_d;
    end
  end

  assign DacData   = dac_q;
  assign DacValid  = valid_q;
  assign PhaseWrap = wrap_q;

endmodule

// File: tb/tb_dds_wave_gen.sv
// Directed bench for dds_wave_gen: hand-computed codes for each waveform,
// wave-select deferral, Ready-low flush and asynchronous reset.
`timescale 1ns/1ps
module tb_dds_wave_gen;

  logic        Fg_CLK = 1'b0;
  logic        RESETn = 1'b0;
  logic        Ready = 1'b0;
  logic        Enable = 1'b0;
  logic [15:0] TuneWord = '0;
  logic [1:0]  WaveSel = '0;
  logic        WaveSelStb = 1'b0;
  logic [7:0]  DacData;
  logic        DacValid;
  logic        PhaseWrap;

  int checks = 0;
  int errors = 0;

  dds_wave_gen #(.PHASE_W(16), .DATA_W(8), .LUT_AW(6)) dut (
    .Fg_CLK     (Fg_CLK),
    .RESETn     (RESETn),
    .Ready      (Ready),
    .Enable     (Enable),
    .TuneWord   (TuneWord),
    .WaveSel    (WaveSel),
    .WaveSelStb (WaveSelStb),
    .DacData    (DacData),
    .DacValid   (DacValid),
    .PhaseWrap  (PhaseWrap)
  );

  always #5 Fg_CLK = ~Fg_CLK;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge Fg_CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [7:0] d, input logic v, input logic w);
    chk({tag, ".data"}, 16'(DacData), 16'(d));
    chk({tag, ".valid"}, 16'(DacValid), 16'(v));
    chk({tag, ".wrap"}, 16'(PhaseWrap), 16'(w));
    $display("txn %s data=0x%02h valid=%0b wrap=%0b", tag, DacData, DacValid, PhaseWrap);
  endtask

  // Park with Ready low and load a waveform selection (applies while idle).
  task automatic idle_select(input logic [1:0] sel);
    Ready = 1'b0; Enable = 1'b0; WaveSelStb = 1'b1; WaveSel = sel;
    tick();
    WaveSelStb = 1'b0;
  endtask

  logic [7:0] sq_exp   [16] = '{8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00,
                                8'h20, 8'h40, 8'h60, 8'h80, 8'hA0, 8'hC0, 8'hE0, 8'h00};
  logic [7:0] sin4_exp [4]  = '{8'hFF, 8'h7D, 8'h00, 8'h82};
  logic [7:0] sin5_exp [5]  = '{8'hB5, 8'hDF, 8'hF9, 8'hFE, 8'hEE};
  logic [7:0] tri_exp  [6]  = '{8'h60, 8'hC0, 8'hDF, 8'h7F, 8'h1F, 8'h40};

  initial begin
    // 1: reset state, then Ready low with Enable pulsing
    #12;
    chk_out("reset", 8'h80, 1'b0, 1'b0);
    @(negedge Fg_CLK);
    RESETn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      Enable = ~Enable;
      tick();
      chk_out($sformatf("idle%0d", i), 8'h80, 1'b0, 1'b0);
    end

    // 2: saw, TuneWord 0x1000, Enable every cycle
    idle_select(2'd1);
    Ready = 1'b1; Enable = 1'b1; TuneWord = 16'h1000;
    tick();
    chk("saw.latency", 16'(DacValid), 16'd0);
    for (int s = 1; s <= 16; s++) begin
      tick();
      chk_out($sformatf("saw%0d", s), 8'(s * 16), 1'b1, s == 16);
    end

    // Ready drop with sample 17 in flight: discarded
    idle_select(2'd0);
    chk_out("flush", 8'h80, 1'b0, 1'b0);

    // 3: square 0x2000, saw selected at sample 2 applies after the wrap
    Ready = 1'b1; Enable = 1'b1; TuneWord = 16'h2000;
    tick();
    for (int s = 1; s <= 16; s++) begin
      WaveSelStb = (s == 2); WaveSel = 2'd1;
      tick();
      chk_out($sformatf("sq%0d", s), sq_exp[s-1], 1'b1, (s == 8) || (s == 16));
    end
    WaveSelStb = 1'b0;

    // 4: sine quadrant points, then interior LUT entries
    idle_select(2'd3);
    Ready = 1'b1; Enable = 1'b1; TuneWord = 16'h4000;
    tick();
    for (int s = 1; s <= 4; s++) begin
      tick();
      chk_out($sformatf("sinq%0d", s), sin4_exp[s-1], 1'b1, s == 4);
    end
    Ready = 1'b0; Enable = 1'b0;
    tick();
    Ready = 1'b1; Enable = 1'b1; TuneWord = 16'h1100;
    tick();
    for (int s = 1; s <= 5; s++) begin
      tick();
      chk_out($sformatf("sinl%0d", s), sin5_exp[s-1], 1'b1, 1'b0);
    end

    // triangle, TuneWord 0x3000
    idle_select(2'd2);
    Ready = 1'b1; Enable = 1'b1; TuneWord = 16'h3000;
    tick();
    for (int s = 1; s <= 6; s++) begin
      tick();
      chk_out($sformatf("tri%0d", s), tri_exp[s-1], 1'b1, s == 6);
    end

    // 5: sparse strobe, Ready dropped between strobe and output
    idle_select(2'd1);
    Ready = 1'b1; Enable = 1'b1; TuneWord = 16'h1000;
    tick();
    Enable = 1'b0; Ready = 1'b0;
    tick();
    chk_out("drop", 8'h80, 1'b0, 1'b0);
    Ready = 1'b1;
    for (int i = 0; i < 98; i++) begin
      tick();
      chk($sformatf("gap%0d.valid", i), 16'(DacValid), 16'd0);
    end
    Enable = 1'b1;
    tick();
    Enable = 1'b0;
    tick();
    chk_out("restart", 8'h10, 1'b1, 1'b0);
    tick();
    chk_out("hold", 8'h10, 1'b0, 1'b0);

    // 6: select strobe coincident with the wrapping strobe
    idle_select(2'd1);
    Ready = 1'b1; Enable = 1'b1; TuneWord = 16'hC000;
    tick();
    WaveSelStb = 1'b1; WaveSel = 2'd0;
    tick();
    WaveSelStb = 1'b0;
    chk_out("coin1", 8'hC0, 1'b1, 1'b0);
    tick();
    chk_out("coin2", 8'hFF, 1'b1, 1'b1);
    tick();
    chk_out("coin3", 8'h00, 1'b1, 1'b1);

    // asynchronous reset mid-run: outputs change before the next edge
    #2;
    RESETn = 1'b0;
    #1;
    chk_out("areset", 8'h80, 1'b0, 1'b0);
    @(negedge Fg_CLK);
    RESETn = 1'b1;
    tick();
    chk("post_reset.valid", 16'(DacValid), 16'd0);
    tick();
    chk_out("post_reset", 8'hFF, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
